vga_timing_gen: RTL and testbench

- Generates the 640x480 @ 60 Hz raster timing that drives the pixel consumer: current pixel coordinates, active-area flag, and a once-per-frame tick.
- Samples the consumer's returned `pixel_rgb`, blanks it outside the active area, and drives the registered colour and sync pins to the monitor.
- Sits between the pixel-clock source and the gameplay logic; it is the initiating end of the xpos/ypos/active/tick → pixel_rgb interface.

---
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for a 640x480 @ 60 Hz display (geometry set by parameters).
// It drives pixel coordinates, an active-area flag and a once-per-frame tick to the
// pixel consumer. It samples the consumer's colour, blanks it outside the visible
// area, and drives registered colour and sync pins to the monitor.
//
// Optional build macro: VGA_SYNC_ALIGN_EN
//   defined   : hsync/vsync are delayed one extra register so they line up with vga_rgb
//   undefined : hsync/vsync change on the same edge as xpos/ypos (they lead vga_rgb by 1 clk)
//
// Ports:
//   clk        in   pixel clock (25 MHz nominal)
//   reset      in   asynchronous, active-high reset
//   pixel_rgb  in   [2:0] colour returned by the consumer for the current xpos/ypos
//   xpos       out  [9:0] horizontal count, 0..H_TOTAL-1
//   ypos       out  [9:0] vertical count, 0..V_TOTAL-1
//   active     out  1 while xpos < H_ACTIVE and ypos < V_ACTIVE
//   tick       out  one-clock pulse at (0, V_ACTIVE), the start of vertical blank
//   hsync      out  horizontal sync, asserted level SYNC_POL
//   vsync      out  vertical sync, asserted level SYNC_POL
//   vga_rgb    out  [2:0] registered, blanked colour
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] pixel_rgb,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       active,
    output logic       tick,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_rgb
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    // The counters are 10 bits wide; a larger raster cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       active_q, active_d;
    logic       tick_q, tick_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [2:0] vga_rgb_q;

    // ---- next counter value and its decodes ----
    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_MAX) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_MAX) ? 10'd0 : vcnt_q + 10'd1;
        end
    end

    // Decoding the next count lets the flags land on the same edge as xpos/ypos.
    always_comb begin
        active_d = (int'(hcnt_d) < H_ACTIVE) && (int'(vcnt_d) < V_ACTIVE);
        tick_d   = (hcnt_d == 10'd0) && (int'(vcnt_d) == V_ACTIVE);
        hsync_d  = ((int'(hcnt_d) >= HS_FIRST) && (int'(hcnt_d) <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = ((int'(vcnt_d) >= VS_FIRST) && (int'(vcnt_d) <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

    // ---- counter / decode register stage ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    // ---- colour register stage ----
    // pixel_rgb belongs to the current xpos/ypos, so active_q is its matching qualifier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_rgb_q <= '0;
        end else begin
            vga_rgb_q <= active_q ? pixel_rgb : 3'b000;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_al_q;
    logic vsync_al_q;

    // ---- sync alignment stage (matches the colour register delay) ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_al_q <= ~SYNC_POL;
            vsync_al_q <= ~SYNC_POL;
        end else begin
            hsync_al_q <= hsync_q;
            vsync_al_q <= vsync_q;
        end
    end

    assign hsync = hsync_al_q;
    assign vsync = vsync_al_q;
`else
    assign hsync = hsync_q;
    assign vsync = vsync_q;
`endif

    assign xpos    = hcnt_q;
    assign ypos    = vcnt_q;
    assign active  = active_q;
    assign tick    = tick_q;
    assign vga_rgb = vga_rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance (16x11 raster, active-low sync)
// and a default-geometry instance (800x525 raster, SYNC_POL = 1), both checked every
// clock against expected states queued by the stimulus process.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol;
    } cfg_t;

    typedef struct packed {
        int h; int v;
        bit act; bit tick;
        bit hs_raw; bit vs_raw;
        bit hs; bit vs;
        int rgb; int pix;
    } st_t;

    localparam cfg_t CA = '{ha: 8, hf: 2, hs: 3, hb: 3, va: 6, vf: 1, vs: 2, vb: 2, pol: 1'b0};
    localparam cfg_t CB = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    bit         pmode = 1'b0;

    logic [9:0] xpos_a, ypos_a, xpos_b, ypos_b;
    logic       active_a, tick_a, hsync_a, vsync_a;
    logic       active_b, tick_b, hsync_b, vsync_b;
    logic [2:0] vga_rgb_a, vga_rgb_b, pix_a, pix_b;

    // Consumer: colour is combinational from the coordinates.
    assign pix_a = pmode ? (xpos_a[2:0] ^ ypos_a[2:0]) : 3'b111;
    assign pix_b = pmode ? (xpos_b[2:0] ^ ypos_b[2:0]) : 3'b111;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .pixel_rgb(pix_a),
        .xpos(xpos_a), .ypos(ypos_a), .active(active_a), .tick(tick_a),
        .hsync(hsync_a), .vsync(vsync_a), .vga_rgb(vga_rgb_a)
    );

    vga_timing_gen #(
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .pixel_rgb(pix_b),
        .xpos(xpos_b), .ypos(ypos_b), .active(active_b), .tick(tick_b),
        .hsync(hsync_b), .vsync(vsync_b), .vga_rgb(vga_rgb_b)
    );

    always #5 clk = ~clk;

    int  n_chk  = 0;
    int  n_pass = 0;
    st_t qa[$];
    st_t qb[$];
    st_t sa, sb;
    bit  ph1 = 1'b0;
    int  cyc = 0;
    int  tick_n = 0;
    int  tick_t1 = 0;
    int  tick_t2 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int pixf(input bit m, input int h, input int v);
        return m ? ((h ^ v) & 7) : 7;
    endfunction

    function automatic st_t rst_state(input cfg_t c);
        st_t s;
        s.h = 0; s.v = 0; s.act = 1'b0; s.tick = 1'b0;
        s.hs_raw = !c.pol; s.vs_raw = !c.pol; s.hs = !c.pol; s.vs = !c.pol;
        s.rgb = 0; s.pix = 0;
        return s;
    endfunction

    function automatic st_t adv(input cfg_t c, input st_t s);
        st_t n;
        int  ht, vt;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        n = s;
        if (s.h == ht - 1) begin
            n.h = 0;
            n.v = (s.v == vt - 1) ? 0 : s.v + 1;
        end else begin
            n.h = s.h + 1;
        end
        n.act    = (n.h < c.ha) && (n.v < c.va);
        n.tick   = (n.h == 0) && (n.v == c.va);
        n.hs_raw = (n.h >= c.ha + c.hf && n.h < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
        n.vs_raw = (n.v >= c.va + c.vf && n.v < c.va + c.vf + c.vs) ? c.pol : !c.pol;
`ifdef VGA_SYNC_ALIGN_EN
        n.hs = s.hs_raw;
        n.vs = s.vs_raw;
`else
        n.hs = n.hs_raw;
        n.vs = n.vs_raw;
`endif
        n.rgb = s.act ? s.pix : 0;
        return n;
    endfunction

    // One clock of stimulus: advance the expected state across the edge using the
    // reset level held at that edge, then apply the new reset/pattern and queue.
    task automatic step(input bit r_new, input bit m_new);
        @(posedge clk);
        #1;
        if (!reset) begin
            sa = adv(CA, sa);
            sb = adv(CB, sb);
        end
        reset = r_new;
        pmode = m_new;
        if (r_new) begin
            sa = rst_state(CA);
            sb = rst_state(CB);
        end
        sa.pix = pixf(pmode, sa.h, sa.v);
        sb.pix = pixf(pmode, sb.h, sb.v);
        qa.push_back(sa);
        qb.push_back(sb);
    endtask

    // Monitor: every clock is an output beat; compare against the queued state.
    always @(negedge clk) begin
        st_t e;
        cyc++;
        if (ph1 && tick_a) begin
            tick_n++;
            if (tick_n == 1) tick_t1 = cyc;
            if (tick_n == 2) tick_t2 = cyc;
        end
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_xpos",   int'(xpos_a),    e.h);
            chk("a_ypos",   int'(ypos_a),    e.v);
            chk("a_active", int'(active_a),  int'(e.act));
            chk("a_tick",   int'(tick_a),    int'(e.tick));
            chk("a_hsync",  int'(hsync_a),   int'(e.hs));
            chk("a_vsync",  int'(vsync_a),   int'(e.vs));
            chk("a_rgb",    int'(vga_rgb_a), e.rgb);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_xpos",   int'(xpos_b),    e.h);
            chk("b_ypos",   int'(ypos_b),    e.v);
            chk("b_active", int'(active_b),  int'(e.act));
            chk("b_tick",   int'(tick_b),    int'(e.tick));
            chk("b_hsync",  int'(hsync_b),   int'(e.hs));
            chk("b_vsync",  int'(vsync_b),   int'(e.vs));
            chk("b_rgb",    int'(vga_rgb_b), e.rgb);
        end
    end

    initial begin
        bit found;
        sa = rst_state(CA);
        sb = rst_state(CB);

        // Reset held for 5 clocks.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

        // Two-plus frames of the small raster with a constant white consumer.
        ph1 = 1'b1;
        for (int i = 0; i < 400; i++) step(1'b0, 1'b0);
        ph1 = 1'b0;

        // Switch to a coordinate pattern, then reset mid-line/mid-frame for one clock.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b0, 1'b1);
            if (sa.h == 5 && sa.v == 3) found = 1'b1;
        end
        chk("midframe_position_reached", int'(found), 1);
        step(1'b1, 1'b1);

        // Long enough for the full-size raster to cover a whole line and its wrap.
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        chk("queues_drained", qa.size() + qb.size(), 0);
        // Small raster: 16 clks/line * 11 lines = 176 clks per frame.
        chk("tick_count", tick_n, 2);
        chk("tick_period", tick_t2 - tick_t1, 176);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
